// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time and
// holds it for the control decoder until the next-PC select resolves it.
module pc_fetch #(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       instr,
  output logic [4:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [2:0]        pc_sel,
  input  logic              pc_sel_valid,
  input  logic              branch_cond,
  input  logic [ADDR_W-1:0] rs_value,
  output logic              halted,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                mis_q, mis_d;

  logic [ADDR_W-1:0]   pc_plus4;
  logic [ADDR_W-1:0]   br_off;
  logic [ADDR_W-1:0]   npc;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign br_off   = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (pc_sel)
      3'b001:  npc = branch_cond ? pc_plus4 + br_off : pc_plus4;
      3'b010:  npc = {pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};
      3'b011:  npc = {rs_value[ADDR_W-1:2], 2'b00};
      3'b100:  npc = pc_q;
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pc_sel_valid) begin
          if (pc_sel == 3'b111) begin
            state_d = S_HALT;
          end else begin
            pc_d    = npc;
            state_d = S_FETCH;
            if (pc_sel == 3'b011 && rs_value[1:0] != 2'b00)
              mis_d = 1'b1;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs decode straight from state so reset drops imem_req at once
  assign imem_req     = (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign opcode       = instr_q[31:27];
  assign instr_valid  = (state_q == S_ISSUE);
  assign pc_out       = pc_q;
  assign halted       = (state_q == S_HALT);
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a transaction-level model of the
// fetch/resolve flow compared against the DUT every cycle.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [4:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [2:0]  pc_sel;
  logic        pc_sel_valid;
  logic        branch_cond;
  logic [31:0] rs_value;
  logic        halted;
  logic        misalign_err;

  pc_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .instr(instr),
    .opcode(opcode),
    .instr_valid(instr_valid),
    .pc_out(pc_out),
    .pc_sel(pc_sel),
    .pc_sel_valid(pc_sel_valid),
    .branch_cond(branch_cond),
    .rs_value(rs_value),
    .halted(halted),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_ISSUE = 2;
  localparam int P_HALT  = 3;

  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_mis;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_next(input logic [31:0] pc,
                                           input logic [31:0] ins,
                                           input logic [2:0] sel,
                                           input logic cond,
                                           input logic [31:0] rs);
    logic [31:0] p4;
    int off;
    p4  = pc + 32'd4;
    off = int'($signed(ins[15:0]));
    case (sel)
      3'd1:    return cond ? p4 + 32'(off * 4) : p4;
      3'd2:    return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
      3'd3:    return rs & ~32'h3;
      3'd4:    return pc;
      default: return p4;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_mis   = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    case (m_phase)
      P_IDLE:  m_phase = P_FETCH;
      P_FETCH: begin
        if (imem_ready) begin
          m_instr = imem_rdata;
          m_phase = P_ISSUE;
        end
      end
      P_ISSUE: begin
        if (pc_sel_valid) begin
          if (pc_sel == 3'd7) begin
            m_phase = P_HALT;
          end else begin
            if (pc_sel == 3'd3 && rs_value[1:0] != 2'b00) m_mis = 1'b1;
            m_pc    = exp_next(m_pc, m_instr, pc_sel, branch_cond, rs_value);
            m_phase = P_FETCH;
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",   32'(imem_req),     32'(m_phase == P_FETCH));
      chk("addr",  imem_addr,         m_pc);
      chk("instr", instr,             m_instr);
      chk("op",    32'(opcode),       32'(m_instr[31:27]));
      chk("valid", 32'(instr_valid),  32'(m_phase == P_ISSUE));
      chk("pcout", pc_out,            m_pc);
      chk("halt",  32'(halted),       32'(m_phase == P_HALT));
      chk("mis",   32'(misalign_err), 32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic fetch(input logic [31:0] rdata, input int stall);
    imem_ready   = 1'b0;
    pc_sel       = 3'b001;
    pc_sel_valid = 1'b1;
    repeat (stall) step();
    imem_ready = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ready   = 1'b0;
    pc_sel_valid = 1'b0;
  endtask

  task automatic resolve(input logic [2:0] sel, input logic cond,
                         input logic [31:0] rs);
    pc_sel       = sel;
    branch_cond  = cond;
    rs_value     = rs;
    pc_sel_valid = 1'b1;
    step();
    pc_sel_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    imem_rdata   = 32'h0;
    imem_ready   = 1'b0;
    pc_sel       = 3'b000;
    pc_sel_valid = 1'b0;
    branch_cond  = 1'b0;
    rs_value     = 32'h0;
    model_reset();
    #12;
    chk("rst_req",   32'(imem_req),     32'h0);
    chk("rst_instr", instr,             32'h0);
    chk("rst_valid", 32'(instr_valid),  32'h0);
    chk("rst_halt",  32'(halted),       32'h0);
    chk("rst_mis",   32'(misalign_err), 32'h0);
    chk("rst_addr",  imem_addr,         32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      fetch(32'h0800_0000, 0);
      chk("seq_op",    32'(opcode),      32'h01);
      chk("seq_valid", 32'(instr_valid), 32'h1);
      resolve(3'b000, 1'b0, 32'h0);
    end

    fetch(32'h1234_0000, 0);
    resolve(3'b000, 1'b0, 32'h0);
    chk("br_pc", imem_addr, 32'h10);
    fetch(32'h0000_FFFE, 0);
    resolve(3'b001, 1'b1, 32'h0);
    chk("br_taken", imem_addr, 32'h0C);
    fetch(32'h1234_0000, 0);
    resolve(3'b000, 1'b0, 32'h0);
    fetch(32'h0000_FFFE, 0);
    resolve(3'b001, 1'b0, 32'h0);
    chk("br_not", imem_addr, 32'h14);

    fetch(32'h1800_0000, 1);
    resolve(3'b011, 1'b0, 32'h1000_0000);
    chk("jr_al", imem_addr, 32'h1000_0000);
    chk("mis0",  32'(misalign_err), 32'h0);
    fetch(32'h1000_0040, 0);
    resolve(3'b010, 1'b0, 32'h0);
    chk("jmp", imem_addr, 32'h1000_0100);
    fetch(32'h1800_0000, 0);
    resolve(3'b011, 1'b0, 32'h0000_2003);
    chk("jr_mis", imem_addr, 32'h2000);
    chk("mis1",   32'(misalign_err), 32'h1);

    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req",   32'(imem_req),    32'h1);
      chk("stall_addr",  imem_addr,        32'h2000);
      chk("stall_valid", 32'(instr_valid), 32'h0);
    end
    fetch(32'hABCD_1234, 0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    imem_ready = 1'b0;
    chk("spur_instr", instr, 32'hABCD_1234);
    resolve(3'b100, 1'b0, 32'h0);
    chk("hold_addr", imem_addr, 32'h2000);
    chk("hold_req",  32'(imem_req), 32'h1);
    fetch(32'h0, 0);
    resolve(3'b110, 1'b0, 32'h0);
    chk("sel6_seq", imem_addr, 32'h2004);
    chk("mis_stk",  32'(misalign_err), 32'h1);

    fetch(32'h0, 0);
    resolve(3'b011, 1'b0, 32'hFFFF_FFFC);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0, 0);
    resolve(3'b000, 1'b0, 32'h0);
    chk("wrap", imem_addr, 32'h0);

    fetch(32'hF800_0000, 0);
    resolve(3'b111, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      imem_ready   = i[0];
      pc_sel_valid = 1'b1;
      pc_sel       = 3'b000;
      step();
      chk("halt_h",   32'(halted),   32'h1);
      chk("halt_req", 32'(imem_req), 32'h0);
    end
    imem_ready   = 1'b0;
    pc_sel_valid = 1'b0;

    rst_n = 1'b0;
    model_reset();
    #2;
    chk("hrst_halt", 32'(halted), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    fetch(32'h0, 0);
    resolve(3'b011, 1'b0, 32'h0000_0301);
    chk("pre_addr", imem_addr, 32'h300);
    imem_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_req",   32'(imem_req),     32'h0);
    chk("mrst_addr",  imem_addr,         32'h0);
    chk("mrst_mis",   32'(misalign_err), 32'h0);
    chk("mrst_valid", 32'(instr_valid),  32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rs_req",  32'(imem_req), 32'h1);
    chk("rs_addr", imem_addr,     32'h0);
    fetch(32'h0800_0000, 2);
    chk("rs_op", 32'(opcode), 32'h01);
    resolve(3'b000, 1'b0, 32'h0);
    chk("rs_next", imem_addr, 32'h4);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
